// File: rtl/audio_nios_sample_fetch_master.sv
// Avalon-MM read initiator: fetches a block of sample-memory words
// into a small FWFT FIFO and streams them to the codec serializer.
module audio_nios_sample_fetch_master #(
  parameter int MEM_WORDS  = 40000,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic [31:0]       sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] next_addr;
  logic [15:0]       count_r;
  logic [15:0]       issued;
  logic              loop_r;
  logic              inflight;
  logic              issue;
  logic              load;
  logic              reload;
  logic              done_n;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       used;
  logic              credit;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;

  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign writedata  = 32'h0;
  assign clken      = 1'b1;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  // A read is only issued when the FIFO is guaranteed room for it
  assign used   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign credit = (used < (CW+1)'(FIFO_DEPTH));
  // Returning data is dropped in the abort cycle
  assign push = inflight && !abort;
  assign pop  = !fifo_empty && sample_ready && !abort;

  assign next_addr = (cur_addr == ADDR_W'(MEM_WORDS - 1))
                   ? '0 : cur_addr + ADDR_W'(1);

  assign chipselect   = issue;
  assign address      = cur_addr;
  assign sample_valid = !fifo_empty;
  assign sample_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign busy         = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, read issue and block control strobes
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    load    = 1'b0;
    reload  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_count != 16'd0) begin
            load    = 1'b1;
            state_n = FETCH;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      FETCH: begin
        if (credit) begin
          issue = 1'b1;
          if (issued + 16'd1 == count_r) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && fifo_empty) begin
          if (loop_r) begin
            reload  = 1'b1;
            state_n = FETCH;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      issue   = 1'b0;
      load    = 1'b0;
      reload  = 1'b0;
      done_n  = 1'b0;
    end
  end

  // Block parameters, address walk, in-flight flag and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      base_r   <= '0;
      count_r  <= '0;
      loop_r   <= 1'b0;
      issued   <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done     <= done_n;
      inflight <= issue;
      if (load) begin
        cur_addr <= base_addr;
        base_r   <= base_addr;
        count_r  <= word_count;
        loop_r   <= loop_en;
        issued   <= '0;
      end else if (reload) begin
        cur_addr <= base_r;
        issued   <= '0;
      end else if (issue) begin
        cur_addr <= next_addr;
        issued   <= issued + 16'd1;
      end
      if (load) underrun <= 1'b0;
      else if (busy && sample_ready && fifo_empty) underrun <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; abort flushes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; empty masks the head word
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= readdata;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(push && fifo_full)
  );

endmodule
